// File: rtl/chocorol_secuenciador.sv
// Program sequencer for the chocorol datapath: fetch / masked execute / write-back per instruction.
// Optional build macro CHOCOROL_SEC_BUCLE_EN repeats the program until parar.
module chocorol_secuenciador #(
  parameter int PROF = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_dir,
  input  logic [19:0]   prog_dato,
  input  logic          inicio,
  input  logic [AW:0]   longitud,
  input  logic          parar,
  output logic [19:0]   Instruccion,
  input  logic [31:0]   Q_final,
  output logic [31:0]   resultado,
  output logic          resultado_valido,
  output logic          ocupado,
  output logic          fin,
  output logic [AW-1:0] pc,
  output logic [15:0]   contador
);

  typedef enum logic [2:0] {REPOSO, LEER, EJEC, ESCR, FIN} estado_t;

  localparam logic [AW:0] PROF_L = (AW+1)'(PROF);

  estado_t     estado, estado_sig;
  logic [19:0] mem [PROF];
  logic [19:0] ir;
  logic [AW:0] limite;
  logic [AW:0] lim_acept;
  logic        ultima;

  assign lim_acept = (longitud > PROF_L) ? PROF_L : longitud;
  assign ultima    = ({1'b0, pc} == (limite - (AW+1)'(1)));

  assign ocupado          = (estado != REPOSO);
  assign fin              = (estado == FIN);
  assign resultado_valido = (estado == ESCR);

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      REPOSO: if (inicio) estado_sig = (lim_acept == '0) ? FIN : LEER;
      LEER:   estado_sig = parar ? FIN : EJEC;
      EJEC:   estado_sig = parar ? FIN : ESCR;
      ESCR: begin
        if (parar)       estado_sig = FIN;
        else if (ultima)
`ifdef CHOCOROL_SEC_BUCLE_EN
                         estado_sig = LEER;
`else
                         estado_sig = FIN;
`endif
        else             estado_sig = LEER;
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= REPOSO;
      pc          <= '0;
      contador    <= '0;
      resultado   <= '0;
      ir          <= '0;
      limite      <= '0;
      Instruccion <= '0;
    end else begin
      estado <= estado_sig;
      unique case (estado)
        REPOSO: if (inicio) begin
          limite   <= lim_acept;
          pc       <= '0;
          contador <= '0;
        end
        LEER: ir        <= mem[pc];
        EJEC: resultado <= Q_final;
        ESCR: begin
          if (contador != 16'hFFFF) contador <= contador + 16'd1;
          if (estado_sig == LEER) pc <= ultima ? '0 : pc + AW'(1);
        end
        default: ;
      endcase

      // Instruccion is registered for the state being entered: write enables are
      // stripped on entry to EJEC and released only on entry to ESCR.
      Instruccion <= '0;
      if (estado == LEER && estado_sig == EJEC)
        Instruccion <= {2'b00, mem[pc][17:0]};
      else if (estado == EJEC && estado_sig == ESCR)
        Instruccion <= ir;
    end
  end

  // NOTE: the program memory has no reset so a reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (!rst && estado == REPOSO && prog_we)
      mem[prog_dir] <= prog_dato;
  end

endmodule
